// File: rtl/mac_result_fifo.sv
// mac_result_fifo: result-vector buffer placed after the 5-lane MAC engine.
// Captures {overflow, 40-bit vector} on every engine strobe, holds up to DEPTH
// entries and presents the head over a valid/ready handshake. Vectors that
// arrive while the buffer is full (and nothing leaves) are dropped and flagged
// on a sticky DROP_o.
// Optional feature: define MAC_RESULT_OVCNT_EN to enable the saturating count
// of accepted overflow vectors on OVCNT_o; otherwise OVCNT_o is tied to zero.
module mac_result_fifo #(
  parameter int DEPTH = 8,
  localparam int LW = $clog2(DEPTH) + 1
) (
  input  logic          CLK,
  input  logic          RSTN,
  input  logic          VAL_i,
  input  logic [39:0]   OUT_i,
  input  logic          OV_i,
  input  logic          RDY_i,
  input  logic          CLR_i,
  output logic [39:0]   DATA_o,
  output logic          OVF_o,
  output logic          VALID_o,
  output logic [LW-1:0] LEVEL_o,
  output logic          FULL_o,
  output logic          DROP_o,
  output logic [7:0]    OVCNT_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

  // Storage: overflow flag kept in bit 40 so it travels with its vector.
  logic [40:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [LW-1:0] level_reg;
  logic [LW-1:0] level_next;
  logic          drop_reg;

  logic full;
  logic empty;
  logic pop;
  logic push;
  logic lost;

  assign full  = (level_reg == FULL_LEVEL);
  assign empty = (level_reg == '0);
  // RDY_i is ignored while empty because pop requires a valid head.
  assign pop   = !empty && RDY_i;
  // A simultaneous pop frees a slot, so a full buffer still accepts.
  assign push  = VAL_i && (!full || pop);
  assign lost  = VAL_i && full && !pop;

  // Array write; the array is deliberately not reset.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr_reg] <= {OV_i, OUT_i};
    end
  end

  // Read/write pointers wrap naturally at DEPTH (power of two).
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  // Occupancy changes only when exactly one of push/pop happens.
  always_comb begin
    level_next = level_reg;
    case ({push, pop})
      2'b10:   level_next = level_reg + 1'b1;
      2'b01:   level_next = level_reg - 1'b1;
      default: level_next = level_reg;
    endcase
  end

  // Occupancy register.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) level_reg <= '0;
    else       level_reg <= level_next;
  end

  // Sticky drop flag; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN)      drop_reg <= 1'b0;
    else if (lost)  drop_reg <= 1'b1;
    else if (CLR_i) drop_reg <= 1'b0;
  end

`ifdef MAC_RESULT_OVCNT_EN
  logic [7:0] ovcnt_reg;

  // Saturating count of accepted overflow vectors; clear beats increment.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      ovcnt_reg <= 8'h00;
    end else if (CLR_i) begin
      ovcnt_reg <= 8'h00;
    end else if (push && OV_i && (ovcnt_reg != 8'hFF)) begin
      ovcnt_reg <= ovcnt_reg + 8'h01;
    end
  end

  assign OVCNT_o = ovcnt_reg;
`else
  assign OVCNT_o = 8'h00;
`endif

  // Head of queue is read straight from the array; stable until popped.
  assign {OVF_o, DATA_o} = mem[rd_ptr_reg];
  assign VALID_o = !empty;
  assign LEVEL_o = level_reg;
  assign FULL_o  = full;
  assign DROP_o  = drop_reg;

endmodule

// File: tb/tb_mac_result_fifo.sv
// tb_mac_result_fifo: directed stimulus for mac_result_fifo with a queue-based
// reference model checked every cycle, plus literal expectations per scenario.
module tb_mac_result_fifo;

  localparam int DEPTH = 8;
  localparam int LW = $clog2(DEPTH) + 1;

  logic          CLK;
  logic          RSTN;
  logic          VAL_i;
  logic [39:0]   OUT_i;
  logic          OV_i;
  logic          RDY_i;
  logic          CLR_i;
  logic [39:0]   DATA_o;
  logic          OVF_o;
  logic          VALID_o;
  logic [LW-1:0] LEVEL_o;
  logic          FULL_o;
  logic          DROP_o;
  logic [7:0]    OVCNT_o;

  int n_pass;
  int n_total;
  bit cmp_en;

  mac_result_fifo #(.DEPTH(DEPTH)) dut (
    .CLK     (CLK),
    .RSTN    (RSTN),
    .VAL_i   (VAL_i),
    .OUT_i   (OUT_i),
    .OV_i    (OV_i),
    .RDY_i   (RDY_i),
    .CLR_i   (CLR_i),
    .DATA_o  (DATA_o),
    .OVF_o   (OVF_o),
    .VALID_o (VALID_o),
    .LEVEL_o (LEVEL_o),
    .FULL_o  (FULL_o),
    .DROP_o  (DROP_o),
    .OVCNT_o (OVCNT_o)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // ---------------- reference model: a bounded queue ----------------
  logic [40:0] q[$];
  bit          m_drop;
  int          m_ovcnt;
  bit          m_pop;
  bit          m_room;

  always @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      q.delete();
      m_drop  = 1'b0;
      m_ovcnt = 0;
    end else begin
      m_pop  = (q.size() != 0) && RDY_i;
      m_room = (q.size() < DEPTH) || m_pop;
      if (m_pop) void'(q.pop_front());
      if (VAL_i && m_room) begin
        q.push_back({OV_i, OUT_i});
        if (OV_i && m_ovcnt < 255) m_ovcnt++;
      end
      if (CLR_i) begin
        m_drop  = 1'b0;
        m_ovcnt = 0;
      end
      if (VAL_i && !m_room) m_drop = 1'b1;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge CLK) begin
    if (cmp_en && RSTN) begin
      chk("m_valid", 64'(VALID_o), 64'(q.size() != 0));
      chk("m_level", 64'(LEVEL_o), 64'(q.size()));
      chk("m_full",  64'(FULL_o),  64'(q.size() == DEPTH));
      chk("m_drop",  64'(DROP_o),  64'(m_drop));
`ifdef MAC_RESULT_OVCNT_EN
      chk("m_ovcnt", 64'(OVCNT_o), 64'(m_ovcnt));
`else
      chk("m_ovcnt", 64'(OVCNT_o), 64'd0);
`endif
      if (q.size() != 0) begin
        chk("m_data", 64'(DATA_o), 64'(q[0][39:0]));
        chk("m_ovf",  64'(OVF_o),  64'(q[0][40]));
      end
    end
  end

  // Apply one cycle of inputs, then return 1 time unit after the edge.
  task automatic step(input logic v, input logic [39:0] d, input logic ov,
                      input logic rdy, input logic clr);
    VAL_i = v; OUT_i = d; OV_i = ov; RDY_i = rdy; CLR_i = clr;
    @(posedge CLK); #1;
    VAL_i = 1'b0; OV_i = 1'b0; RDY_i = 1'b0; CLR_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_pass = 0; n_total = 0; cmp_en = 1'b0;
    RSTN = 1'b0; VAL_i = 1'b0; OUT_i = '0; OV_i = 1'b0; RDY_i = 1'b0; CLR_i = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_valid", 64'(VALID_o), 64'd0);
    chk("rst_level", 64'(LEVEL_o), 64'd0);
    chk("rst_full",  64'(FULL_o),  64'd0);
    chk("rst_drop",  64'(DROP_o),  64'd0);
    chk("rst_ovcnt", 64'(OVCNT_o), 64'd0);
    RSTN = 1'b1;
    cmp_en = 1'b1;
    @(posedge CLK); #1;

    // Single vector, no bypass
    step(1, 40'h05_04_03_02_01, 0, 0, 0);
    chk("single_valid", 64'(VALID_o), 64'd1);
    chk("single_data",  64'(DATA_o),  64'h05_04_03_02_01);
    chk("single_level", 64'(LEVEL_o), 64'd1);
    step(0, '0, 0, 1, 0);
    chk("single_valid_after_pop", 64'(VALID_o), 64'd0);
    chk("single_level_after_pop", 64'(LEVEL_o), 64'd0);

    // Fill and drop
    for (int i = 1; i <= 9; i++) step(1, 40'(i), 0, 0, 0);
    chk("fill_full",  64'(FULL_o),  64'd1);
    chk("fill_level", 64'(LEVEL_o), 64'd8);
    chk("fill_drop",  64'(DROP_o),  64'd1);
    for (int i = 1; i <= 8; i++) begin
      chk("fill_drain_data", 64'(DATA_o), 64'(i));
      step(0, '0, 0, 1, 0);
    end
    chk("fill_empty_after_drain", 64'(VALID_o), 64'd0);
    chk("fill_drop_sticky", 64'(DROP_o), 64'd1);
    step(0, '0, 0, 0, 1);
    chk("clr_drop", 64'(DROP_o), 64'd0);

    // Full with simultaneous push and pop
    for (int i = 1; i <= 8; i++) step(1, 40'(i), 0, 0, 0);
    chk("pp_full", 64'(FULL_o), 64'd1);
    step(1, 40'd9, 0, 1, 0);
    chk("pp_level", 64'(LEVEL_o), 64'd8);
    chk("pp_drop",  64'(DROP_o),  64'd0);
    for (int i = 2; i <= 9; i++) begin
      chk("pp_drain_data", 64'(DATA_o), 64'(i));
      step(0, '0, 0, 1, 0);
    end
    chk("pp_empty", 64'(VALID_o), 64'd0);

    // Wrap-around streaming at one vector per cycle
    for (int i = 0; i < 20; i++) begin
      step(1, 40'h1000 + 40'(i), 0, 1, 0);
      chk("stream_level", 64'(LEVEL_o), 64'd1);
      chk("stream_data",  64'(DATA_o),  64'h1000 + 64'(i));
    end
    step(0, '0, 0, 1, 0);
    chk("stream_empty", 64'(LEVEL_o), 64'd0);

    // Overflow flag tracking
    step(1, 40'h11, 1, 0, 0);
    step(1, 40'h22, 0, 0, 0);
    step(1, 40'h33, 1, 0, 0);
`ifdef MAC_RESULT_OVCNT_EN
    chk("ov_count", 64'(OVCNT_o), 64'd2);
`else
    chk("ov_count", 64'(OVCNT_o), 64'd0);
`endif
    chk("ov_flag0", 64'(OVF_o), 64'd1);
    step(0, '0, 0, 1, 0);
    chk("ov_flag1", 64'(OVF_o), 64'd0);
    step(0, '0, 0, 1, 0);
    chk("ov_flag2", 64'(OVF_o), 64'd1);
    chk("ov_data2", 64'(DATA_o), 64'h33);
    step(0, '0, 0, 1, 0);
    step(0, '0, 0, 0, 1);
    chk("ov_count_clr", 64'(OVCNT_o), 64'd0);
    chk("ov_drop_clr",  64'(DROP_o),  64'd0);

    // Drop in the same cycle as a clear: drop wins
    for (int i = 0; i < 8; i++) step(1, 40'hA0 + 40'(i), 0, 0, 0);
    step(1, 40'hFF, 1, 0, 1);
    chk("clr_drop_same_cycle", 64'(DROP_o), 64'd1);
    chk("clr_drop_level", 64'(LEVEL_o), 64'd8);
    for (int i = 0; i < 8; i++) step(0, '0, 0, 1, 0);

    // Asynchronous reset mid-cycle
    for (int i = 0; i < 5; i++) step(1, 40'h50 + 40'(i), 0, 0, 0);
    chk("arst_pre_level", 64'(LEVEL_o), 64'd5);
    chk("arst_pre_drop",  64'(DROP_o),  64'd1);
    #1 RSTN = 1'b0;
    #1;
    chk("arst_valid", 64'(VALID_o), 64'd0);
    chk("arst_level", 64'(LEVEL_o), 64'd0);
    chk("arst_full",  64'(FULL_o),  64'd0);
    chk("arst_drop",  64'(DROP_o),  64'd0);
    chk("arst_ovcnt", 64'(OVCNT_o), 64'd0);
    #1 RSTN = 1'b1;
    @(posedge CLK); #1;
    step(1, 40'hAB_CD, 0, 0, 0);
    chk("arst_push_level", 64'(LEVEL_o), 64'd1);
    chk("arst_push_data",  64'(DATA_o),  64'hAB_CD);
    step(0, '0, 0, 1, 0);
    chk("arst_final_empty", 64'(VALID_o), 64'd0);

    @(posedge CLK); #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mac_result_fifo.md
# mac_result_fifo

Output buffer that sits directly downstream of the 5-lane MAC matrix-multiply engine. It captures every result vector the engine emits (40-bit word = five 8-bit lanes, plus an overflow flag). It holds the vectors in a small FIFO and hands them to the consumer over a valid/ready handshake. The engine has no back-pressure input, so this block absorbs bursts, reports dropped vectors, and keeps per-vector overflow status aligned with the data.

## Interface
- `DEPTH`, 8 — number of 41-bit entries (40 data + 1 overflow); power of two, ≥ 2.
- `LW`, `$clog2(DEPTH)+1` — width of level output (localparam, derived).

- `CLK` in 1 — single clock, rising edge.
- `RSTN` in 1 — asynchronous, active-low reset.
- `VAL_i` in 1 — engine result strobe; one vector per high cycle.
- `OUT_i` in 40 — engine result vector, lane k = bits [8k+7:8k].
- `OV_i` in 1 — engine overflow flag for the same vector.
- `RDY_i` in 1 — consumer ready.
- `DATA_o` out 40 — head-of-FIFO vector.
- `OVF_o` out 1 — overflow flag of head entry.
- `VALID_o` out 1 — head entry valid.
- `LEVEL_o` out LW — current occupancy, 0..DEPTH.
- `FULL_o` out 1 — LEVEL_o == DEPTH.
- `DROP_o` out 1 — sticky: a vector was lost because the FIFO was full.
- `CLR_i` in 1 — synchronous clear of DROP_o and OVCNT_o.
- `OVCNT_o` out 8 — count of accepted vectors with OV_i=1 (see Configuration).

## Operation
- Storage: DEPTH×41 register array, write pointer, read pointer (log2 DEPTH bits, natural wrap), occupancy counter.
- Push: `VAL_i` high at an edge and (not full, or a pop in the same cycle). Writes {OV_i, OUT_i} at the write pointer. The write pointer increments.
- Pop: `VALID_o && RDY_i` at an edge. The read pointer increments.
- Level: +1 on push only, −1 on pop only, unchanged on both or neither.
- Full and push with simultaneous pop: both occur, and the vector is accepted. Full and push without pop: the vector is discarded, no state changes, and `DROP_o` is set.
- Empty and push: no bypass. The vector appears on outputs the following cycle.
- `VALID_o` = (level ≠ 0). `DATA_o` and `OVF_o` are read from the array at the read pointer. They are stable while `VALID_o && !RDY_i`.
- `RDY_i` while empty is ignored.
- `CLR_i`: clears `DROP_o` and `OVCNT_o` at the edge; FIFO contents are untouched. If a drop happens in the same cycle as `CLR_i`, the set wins and `DROP_o` = 1.
- No data transformation; lanes pass bit-exact.

## Timing
- Reset (RSTN low, asynchronous): pointers and level = 0, `VALID_o`=0, `FULL_o`=0, `DROP_o`=0, `OVCNT_o`=0, `LEVEL_o`=0. `DATA_o`/`OVF_o` are don't-care while `VALID_o`=0; the array itself is not reset.
- Reset mid-operation: all buffered vectors are lost. The first `VAL_i` after RSTN deasserts is accepted normally.
- Latency: push at edge n gives `VALID_o`=1 after edge n (visible in cycle n+1) when the FIFO was empty.
- Throughput: one push and one pop per cycle sustained. `LEVEL_o` and `FULL_o` update on the same edge as the pointer movement.
- The engine's VAL_o is a single-cycle pulse per computation, so back-to-back pushes at 1/cycle must be supported anyway.

## Configuration
- `MAC_RESULT_OVCNT_EN` defined: `OVCNT_o` increments by 1 on every push with `OV_i`=1. It saturates at 8'hFF (no wrap). It is cleared by `CLR_i` (clear wins over increment). Dropped vectors are not counted.
- Undefined: the counter logic is absent and `OVCNT_o` is tied to 8'h00. The port list is identical in both builds.

## Test plan
- Single vector: reset, push OUT_i=40'h05_04_03_02_01, OV_i=0 with RDY_i=0 → next cycle VALID_o=1, DATA_o=40'h0504030201, LEVEL_o=1. Then RDY_i=1 for one cycle → VALID_o=0, LEVEL_o=0.
- Fill and drop (DEPTH=8): push 9 vectors (values 1..9) with RDY_i=0 → FULL_o=1, LEVEL_o=8, DROP_o=1. Then drain → outputs 1..8 in order and 9 is never seen.
- Full with simultaneous push/pop: FIFO full of 1..8, push 9 with RDY_i=1 → LEVEL_o stays 8, DROP_o stays 0, drain order 2..9.
- Wrap-around: stream 20 vectors at 1/cycle with RDY_i=1 constantly → all 20 emerge in order one cycle late, and LEVEL_o never exceeds 1.
- Overflow tracking: push 3 vectors with OV_i=1,0,1 → OVF_o reads 1,0,1 in sequence. With macro defined, OVCNT_o=2, and CLR_i → OVCNT_o=0, DROP_o=0; without the macro, OVCNT_o=0 throughout.
- Async reset: with LEVEL_o=5, pulse RSTN low mid-cycle → outputs go to reset values immediately (before the next edge), and a subsequent push yields LEVEL_o=1.
